// File: rtl/timer_bank.sv
// Bank of NCH prescaled up-counters with compare match, auto-reload and
// per-channel interrupts, accessed through a word-addressed register file.
module timer_bank #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned RESET_COMPARE = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [5:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [NCH-1:0]   irq,
  output logic             irq_any
);

  localparam int unsigned PS_W = 8;
  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_COUNT   = 2'd1;
  localparam logic [1:0] SEL_COMPARE = 2'd2;
  localparam logic [1:0] SEL_STATUS  = 2'd3;

  logic [NCH-1:0]   en;
  logic [NCH-1:0]   ar;
  logic [NCH-1:0]   ie;
  logic [NCH-1:0]   pending;
  logic [PS_W-1:0]  ps      [NCH];
  logic [PS_W-1:0]  pc      [NCH];
  logic [WIDTH-1:0] count   [NCH];
  logic [WIDTH-1:0] compare [NCH];

  logic [NCH-1:0] tick;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] wr_ctrl;
  logic [NCH-1:0] wr_count;
  logic [NCH-1:0] wr_compare;
  logic [NCH-1:0] wr_status;

  logic [3:0] ch_sel;
  logic [1:0] reg_sel;

  assign ch_sel  = addr[5:2];
  assign reg_sel = addr[1:0];

  // Write decode and per-channel tick/hit qualification from current state.
  always_comb begin
    wr_ctrl    = '0;
    wr_count   = '0;
    wr_compare = '0;
    wr_status  = '0;
    tick       = '0;
    hit        = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      wr_ctrl[i]    = we && (ch_sel == 4'(i)) && (reg_sel == SEL_CTRL);
      wr_count[i]   = we && (ch_sel == 4'(i)) && (reg_sel == SEL_COUNT);
      wr_compare[i] = we && (ch_sel == 4'(i)) && (reg_sel == SEL_COMPARE);
      wr_status[i]  = we && (ch_sel == 4'(i)) && (reg_sel == SEL_STATUS);
      tick[i]       = en[i] && (pc[i] == ps[i]);
      hit[i]        = tick[i] && (count[i] == compare[i]);
    end
  end

  // Channel state; software writes take priority over timer updates except
  // that a hit always sets pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= '0;
      ar      <= '0;
      ie      <= '0;
      pending <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        ps[i]      <= '0;
        pc[i]      <= '0;
        count[i]   <= '0;
        compare[i] <= WIDTH'(RESET_COMPARE);
      end
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (wr_ctrl[i]) begin
          en[i] <= wdata[0];
          ar[i] <= wdata[1];
          ie[i] <= wdata[2];
          ps[i] <= wdata[15:8];
        end else if (hit[i] && !ar[i]) begin
          en[i] <= 1'b0;
        end

        if (wr_ctrl[i] || tick[i]) begin
          pc[i] <= '0;
        end else if (en[i]) begin
          pc[i] <= pc[i] + PS_W'(1);
        end

        if (wr_count[i]) begin
          count[i] <= wdata;
        end else if (hit[i]) begin
          if (ar[i]) begin
            count[i] <= '0;
          end
        end else if (tick[i]) begin
          count[i] <= count[i] + WIDTH'(1);
        end

        if (wr_compare[i]) begin
          compare[i] <= wdata;
        end

        if (hit[i]) begin
          pending[i] <= 1'b1;
        end else if (wr_status[i] && wdata[0]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  assign irq     = pending & ie;
  assign irq_any = |irq;

  // Read mux; out-of-range channels and unused bits read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (ch_sel == 4'(i)) begin
        case (reg_sel)
          SEL_CTRL: begin
            rdata[15:8] = ps[i];
            rdata[2:0]  = {ie[i], ar[i], en[i]};
          end
          SEL_COUNT:   rdata    = count[i];
          SEL_COMPARE: rdata    = compare[i];
          default:     rdata[0] = pending[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed corner cases plus randomized
// register traffic checked against a behavioural model of the timer rules.
module tb_timer_bank;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [5:0]    addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic [NCH-1:0] irq;
  logic          irq_any;

  int n_checks = 0;
  int n_fail   = 0;

  timer_bank #(.NCH(NCH), .WIDTH(W), .RESET_COMPARE(500)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .irq_any(irq_any)
  );

  always #20 clk = ~clk;

  // Behavioural model: CTRL kept as its readable word, count as plain numbers.
  bit [31:0] m_ctrl [NCH];
  bit [31:0] m_count[NCH];
  bit [31:0] m_cmp  [NCH];
  int        m_pc   [NCH];
  bit        m_pend [NCH];

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ctrl[i] = 0; m_count[i] = 0; m_cmp[i] = 500; m_pc[i] = 0; m_pend[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic w, input logic [5:0] a, input logic [31:0] d);
    int ch;
    int sel;
    ch  = int'(a[5:2]);
    sel = int'(a[1:0]);
    for (int i = 0; i < NCH; i++) begin
      bit run, reload, do_tick, match, wr;
      int ps;
      run     = m_ctrl[i][0];
      reload  = m_ctrl[i][1];
      ps      = int'(m_ctrl[i][15:8]);
      do_tick = run && (m_pc[i] == ps);
      match   = do_tick && (m_count[i] == m_cmp[i]);
      wr      = w && (ch == i);
      if (wr && sel == 0) m_pc[i] = 0;
      else if (run) m_pc[i] = do_tick ? 0 : m_pc[i] + 1;
      if (wr && sel == 1) m_count[i] = d;
      else if (match) m_count[i] = reload ? 32'd0 : m_count[i];
      else if (do_tick) m_count[i] = 32'((64'(m_count[i]) + 64'd1) % (64'd1 << 32));
      if (match) m_pend[i] = 1'b1;
      else if (wr && sel == 3 && d[0]) m_pend[i] = 1'b0;
      if (wr && sel == 2) m_cmp[i] = d;
      if (wr && sel == 0) m_ctrl[i] = d & 32'h0000_FF07;
      else if (match && !reload) m_ctrl[i][0] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int ch;
    ch = int'(a[5:2]);
    if (ch >= NCH) return 32'd0;
    case (a[1:0])
      2'd0:    return m_ctrl[ch];
      2'd1:    return m_count[ch];
      2'd2:    return m_cmp[ch];
      default: return {31'd0, m_pend[ch]};
    endcase
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_pend[i] & m_ctrl[i][2];
    return v;
  endfunction

  // One clock with the given bus cycle; returns 1 time unit after the edge.
  task automatic clk_cycle(input logic w, input logic [5:0] a, input logic [31:0] d);
    we = w; addr = a; wdata = d;
    @(posedge clk);
    if (rst) model_reset(); else model_step(w, a, d);
    #1;
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      n_checks++;
      if (rdata !== model_read(6'(a))) begin
        n_fail++;
        $display("FAIL reset_rdata addr=%h got=%h exp=%h", a, rdata, model_read(6'(a)));
      end
    end
    n_checks++;
    if (irq !== 4'h0 || irq_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got=%b/%b exp=0000/0", irq, irq_any);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_autoreload();
    logic [31:0] exp_seq [6];
    exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    do_reset();
    clk_cycle(1'b1, 6'h02, 32'd3);
    clk_cycle(1'b1, 6'h00, 32'h7);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) clk_cycle(1'b0, 6'h01, 32'd0);
      addr = 6'h01;
      #1;
      n_checks++;
      if (rdata !== exp_seq[k] || rdata !== model_read(6'h01)) begin
        n_fail++;
        $display("FAIL autoreload_count k=%0d got=%0d exp=%0d", k, rdata, exp_seq[k]);
      end
      n_checks++;
      if (irq[0] !== (k >= 4) || irq_any !== (k >= 4) || irq !== model_irq()) begin
        n_fail++;
        $display("FAIL autoreload_irq k=%0d got=%b/%b exp_irq0=%0d", k, irq, irq_any, k >= 4);
      end
    end
  endtask

  task automatic test_oneshot_prescale();
    logic [31:0] exp;
    do_reset();
    clk_cycle(1'b1, 6'h06, 32'd2);
    clk_cycle(1'b1, 6'h04, 32'h0201);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) clk_cycle(1'b0, 6'h05, 32'd0);
      exp = (k >= 6) ? 32'd2 : 32'(k / 3);
      addr = 6'h05;
      #1;
      n_checks++;
      if (rdata !== exp || rdata !== model_read(6'h05)) begin
        n_fail++;
        $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, rdata, exp);
      end
    end
    addr = 6'h04;
    #1;
    n_checks++;
    if (rdata !== 32'h0200) begin
      n_fail++;
      $display("FAIL oneshot_ctrl got=%h exp=00000200", rdata);
    end
    addr = 6'h07;
    #1;
    n_checks++;
    if (rdata !== 32'd1 || irq[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_status got=%h irq1=%b exp=1 irq1=0", rdata, irq[1]);
    end
  endtask

  task automatic test_pending_clear_race();
    do_reset();
    clk_cycle(1'b1, 6'h0A, 32'd1);
    clk_cycle(1'b1, 6'h08, 32'h7);
    clk_cycle(1'b0, 6'h0B, 32'd0);
    clk_cycle(1'b0, 6'h0B, 32'd0);
    #1;
    n_checks++;
    if (rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL pclr_first_hit got=%h exp=1", rdata);
    end
    clk_cycle(1'b0, 6'h0B, 32'd0);
    clk_cycle(1'b1, 6'h0B, 32'd1);
    addr = 6'h0B;
    #1;
    n_checks++;
    if (rdata !== 32'd1 || irq[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL pclr_race got=%h irq2=%b exp=1 irq2=1", rdata, irq[2]);
    end
    clk_cycle(1'b1, 6'h0B, 32'd1);
    addr = 6'h0B;
    #1;
    n_checks++;
    if (rdata !== 32'd0 || irq[2] !== 1'b0 || rdata !== model_read(6'h0B)) begin
      n_fail++;
      $display("FAIL pclr_clear got=%h irq2=%b exp=0 irq2=0", rdata, irq[2]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    do_reset();
    clk_cycle(1'b1, 6'h0D, 32'hFFFF_FFFE);
    clk_cycle(1'b1, 6'h0E, 32'd5);
    clk_cycle(1'b1, 6'h0C, 32'h7);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) clk_cycle(1'b0, 6'h0D, 32'd0);
      exp = (k == 8) ? 32'd0 : 32'hFFFF_FFFE + 32'(k);
      addr = 6'h0D;
      #1;
      n_checks++;
      if (rdata !== exp) begin
        n_fail++;
        $display("FAIL wrap_count k=%0d got=%h exp=%h", k, rdata, exp);
      end
      addr = 6'h0F;
      #1;
      n_checks++;
      if (rdata !== 32'(k == 8) || irq[3] !== (k == 8)) begin
        n_fail++;
        $display("FAIL wrap_pending k=%0d got=%h irq3=%b exp=%0d", k, rdata, irq[3], k == 8);
      end
    end
  endtask

  task automatic test_count_write_race();
    do_reset();
    clk_cycle(1'b1, 6'h02, 32'd1000);
    clk_cycle(1'b1, 6'h00, 32'h1);
    repeat (3) clk_cycle(1'b0, 6'h01, 32'd0);
    clk_cycle(1'b1, 6'h01, 32'd100);
    addr = 6'h01;
    #1;
    n_checks++;
    if (rdata !== 32'd100) begin
      n_fail++;
      $display("FAIL cwr_write_wins got=%0d exp=100", rdata);
    end
    clk_cycle(1'b0, 6'h05, 32'd0);
    #1;
    n_checks++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL cwr_ch1_count got=%h exp=0", rdata);
    end
    addr = 6'h3C;
    #1;
    n_checks++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL cwr_bad_ch_read got=%h exp=0", rdata);
    end
    clk_cycle(1'b1, 6'h3C, $urandom());
    clk_cycle(1'b1, 6'h3E, 32'd7);
    for (int a = 0; a < 16; a++) begin
      addr = 6'(a);
      #1;
      n_checks++;
      if (rdata !== model_read(6'(a))) begin
        n_fail++;
        $display("FAIL cwr_regs addr=%h got=%h exp=%h", a, rdata, model_read(6'(a)));
      end
    end
    addr = 6'h3C;
    #1;
    n_checks++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL cwr_bad_ch_after_write got=%h exp=0", rdata);
    end
    // Count write landing on a hit: write value kept, pending still set.
    clk_cycle(1'b1, 6'h06, 32'd0);
    clk_cycle(1'b1, 6'h04, 32'h3);
    clk_cycle(1'b1, 6'h05, 32'd50);
    addr = 6'h05;
    #1;
    n_checks++;
    if (rdata !== 32'd50) begin
      n_fail++;
      $display("FAIL cwr_hit_count got=%0d exp=50", rdata);
    end
    addr = 6'h07;
    #1;
    n_checks++;
    if (rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL cwr_hit_pending got=%h exp=1", rdata);
    end
  endtask

  task automatic test_ctrl_race();
    do_reset();
    clk_cycle(1'b1, 6'h02, 32'd2);
    clk_cycle(1'b1, 6'h00, 32'h3);
    clk_cycle(1'b0, 6'h01, 32'd0);
    clk_cycle(1'b0, 6'h01, 32'd0);
    #1;
    n_checks++;
    if (rdata !== 32'd2) begin
      n_fail++;
      $display("FAIL ctrl_race_pre got=%0d exp=2", rdata);
    end
    clk_cycle(1'b1, 6'h00, 32'h0);
    addr = 6'h03;
    #1;
    n_checks++;
    if (rdata !== 32'd1) begin
      n_fail++;
      $display("FAIL ctrl_race_pending got=%h exp=1", rdata);
    end
    addr = 6'h00;
    #1;
    n_checks++;
    if (rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL ctrl_race_ctrl got=%h exp=0", rdata);
    end
    for (int k = 0; k < 3; k++) begin
      clk_cycle(1'b0, 6'h01, 32'd0);
      n_checks++;
      if (rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL ctrl_race_hold k=%0d got=%0d exp=0", k, rdata);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NCH-1:0] exp;
    do_reset();
    for (int i = 0; i < NCH; i++) clk_cycle(1'b1, {4'(i), 2'd2}, 32'(9 - i));
    for (int e = 0; e <= 12; e++) begin
      if (e < NCH) clk_cycle(1'b1, {4'(e), 2'd0}, 32'h5);
      else clk_cycle(1'b0, 6'h01, 32'd0);
      exp = (e >= 10) ? 4'hF : 4'h0;
      n_checks++;
      if (irq !== exp || irq !== model_irq() || irq_any !== (e >= 10)) begin
        n_fail++;
        $display("FAIL simul_irq e=%0d got=%b exp=%b", e, irq, exp);
      end
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    clk_cycle(1'b1, 6'h02, 32'd3);
    clk_cycle(1'b1, 6'h00, 32'h7);
    clk_cycle(1'b0, 6'h01, 32'd0);
    clk_cycle(1'b0, 6'h01, 32'd0);
    #1;
    n_checks++;
    if (rdata !== 32'd2) begin
      n_fail++;
      $display("FAIL rstmid_pre got=%0d exp=2", rdata);
    end
    rst = 1'b1;
    model_reset();
    #1;
    for (int a = 0; a < 16; a++) begin
      addr = 6'(a);
      #1;
      n_checks++;
      if (rdata !== model_read(6'(a))) begin
        n_fail++;
        $display("FAIL rstmid_regs addr=%h got=%h exp=%h", a, rdata, model_read(6'(a)));
      end
    end
    addr = 6'h02;
    #1;
    n_checks++;
    if (rdata !== 32'd500 || irq !== 4'h0) begin
      n_fail++;
      $display("FAIL rstmid_compare got=%0d irq=%b exp=500 irq=0000", rdata, irq);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clk_cycle(1'b0, 6'h03, 32'd0);
      n_checks++;
      if (rdata !== 32'd0 || irq !== 4'h0) begin
        n_fail++;
        $display("FAIL rstmid_after k=%0d pending=%h irq=%b exp=0", k, rdata, irq);
      end
    end
  endtask

  task automatic test_random();
    logic        w;
    logic [5:0]  a;
    logic [5:0]  ra;
    logic [31:0] d;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (irq !== 4'h0 || irq_any !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_reset_irq n=%0d got=%b/%b exp=0", n, irq, irq_any);
        end
        @(posedge clk);
        #1 rst = 1'b0;
      end
      w = ($urandom_range(0, 99) < 35);
      a = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
      d = $urandom();
      case (a[1:0])
        2'd0: begin
          d[15:8] = 8'($urandom_range(0, 3));
          d[0]    = ($urandom_range(0, 3) != 0);
        end
        2'd1: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                               : 32'($urandom_range(0, 12));
        2'd2: d = 32'($urandom_range(0, 12));
        default: ;
      endcase
      clk_cycle(w, a, d);
      n_checks++;
      if (irq !== model_irq() || irq_any !== (|model_irq())) begin
        n_fail++;
        $display("FAIL rand_irq n=%0d got=%b/%b exp=%b", n, irq, irq_any, model_irq());
      end
      ra = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
      addr = ra;
      #1;
      n_checks++;
      if (rdata !== model_read(ra)) begin
        n_fail++;
        $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, ra, rdata, model_read(ra));
      end
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_autoreload();
    test_oneshot_prescale();
    test_pending_clear_race();
    test_wrap();
    test_count_write_race();
    test_ctrl_race();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent timer channels, range 1..16.
REQ-002 Parameter WIDTH, default 32: counter/compare width and data bus width.
REQ-003 Parameter RESET_COMPARE, default 500: compare value loaded at reset.
REQ-004 clk  input  1  clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 we  input  1  register write strobe, sampled on posedge clk.
REQ-007 addr  input  6  word address: addr[5:2] channel index, addr[1:0] register select.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 rdata  output  WIDTH  read data, combinational from addr.
REQ-010 irq  output  NCH  per-channel interrupt, bit i = pending[i] AND ie[i].
REQ-011 irq_any  output  1  OR-reduction of irq.

Function
REQ-012 Per-channel registers: sel 0 CTRL, sel 1 COUNT, sel 2 COMPARE, sel 3 STATUS.
REQ-013 CTRL layout: bit0 en, bit1 auto-reload (ar), bit2 interrupt enable (ie), bits[15:8] prescale (PS); other bits read 0.
REQ-014 STATUS: bit0 pending; write with wdata[0]=1 clears pending, wdata[0]=0 no effect; other bits read 0.
REQ-015 Channel index >= NCH: writes ignored, reads return 0.
REQ-016 Each channel has an 8-bit prescale counter pc; while en=1, pc increments each clk; when pc == PS a tick occurs and pc returns to 0 in the same cycle.
REQ-017 PS=0: a tick every clk while en=1.
REQ-018 en=0: pc and COUNT hold; no ticks.
REQ-019 On a tick with COUNT != COMPARE: COUNT <= COUNT+1, modulo 2^WIDTH (all-ones wraps to 0, no flag).
REQ-020 On a tick with COUNT == COMPARE (hit): pending <= 1; if ar=1 COUNT <= 0 and en stays 1; if ar=0 COUNT holds and en <= 0 (one-shot).
REQ-021 Hit-to-pending latency: pending visible the cycle after the hitting clk edge; irq follows combinationally.
REQ-022 Write to CTRL clears that channel's pc to 0.
REQ-023 Software write to COUNT in the same cycle as a tick: write value wins, increment/reload discarded, pending still set if the pre-write COUNT matched COMPARE.
REQ-024 Pending clear in same cycle as a hit: set wins, pending=1.
REQ-025 Write to CTRL clearing en in the same cycle as a hit: hit still sets pending; en=0 afterwards.
REQ-026 COMPARE written below current COUNT: counter runs to all-ones, wraps to 0, then hits on reaching COMPARE.
REQ-027 Channels are fully independent; simultaneous hits on several channels set all respective pending bits in the same cycle.

Reset
REQ-028 While rst=1, all channels: CTRL=0, COUNT=0, pc=0, pending=0, COMPARE=RESET_COMPARE; irq=0, irq_any=0.
REQ-029 Reset asserted mid-count aborts the channel immediately; no pending set on the reset cycle or the first cycle after release.
REQ-030 rdata reflects the reset register values while rst=1.

Verification
REQ-031 Ch0 COMPARE=3, CTRL=0x7 (en, ar, ie, PS=0) -> COUNT sequence 0,1,2,3,0,...; pending and irq[0] rise the cycle after COUNT==3 is ticked; irq_any=1.
REQ-032 Ch1 COMPARE=2, CTRL=0x0201 (en, PS=2, one-shot) -> COUNT advances every 3rd clk, stops at 2, CTRL reads 0x0200, pending=1, irq[1]=0 (ie=0).
REQ-033 Ch2 pending=1, write STATUS=1 on the same clk as a new hit -> pending remains 1; next write STATUS=1 with no hit -> pending=0, irq[2]=0.
REQ-034 Ch3 COUNT=0xFFFFFFFE, COMPARE=5, ar=1, PS=0 -> COUNT 0xFFFFFFFF, 0, 1,...,5, then hit; no pending at the wrap.
REQ-035 Write ch0 COUNT=100 on a tick cycle, then read addr 5 (ch1 COUNT) and addr 0x3C (ch15 with NCH=4) -> ch0 COUNT=100 next cycle; addr 0x3C reads 0, write to it has no effect.
REQ-036 Assert rst for 1 cycle while ch0 running at COUNT=2 -> all registers at reset values, COMPARE reads 500, irq=0.
